program_loader: RTL and testbench

//  Writer side of the program-memory interface: the CPU only reads program memory; this block fills it.

---
 rtl/program_loader_pkg.sv | 20 ++
 rtl/program_loader.sv | 159 +++++++++++++++
 tb/tb_program_loader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and its neighbours.
// Holds the byte width of the host link, the instruction opcode field width,
// the HALT opcode (also used by the CPU decoder) and the loader state encoding.
package program_loader_pkg;

  localparam int BYTE_W       = 8;
  localparam int OPCODE_WIDTH = 5;

  // Opcode that terminates a load; the CPU decoder uses the same constant.
  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 5'b00000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_LO = 3'd1,
    ST_LOAD_HI = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

endpackage

// File: rtl/program_loader.sv
// program_loader
// Writer side of program memory. Assembles a byte stream from the host link
// into 16-bit instructions (low byte first), writes them to PM from address 0,
// and holds the CPU in reset until a HALT word or the last PM address has been
// written.
//
// Ports
//   CLK       in   clock, rising edge
//   RESET     in   synchronous, active-low reset
//   LOAD_REQ  in   1-cycle pulse: (re)start a load at address 0
//   RUN_REQ   in   1-cycle pulse: run the program already in PM (IDLE only)
//   RX_DATA   in   incoming byte
//   RX_VALID  in   RX_DATA valid
//   RX_READY  out  loader accepts a byte this cycle
//   PM_WE     out  PM write strobe, one cycle per word
//   PM_ADDR   out  PM write address (holds last written address when idle)
//   PM_WDATA  out  PM write data {hi,lo}
//   CPU_RUN   out  1 = CPU may execute
//   BUSY      out  1 while loading (LOAD_LO/LOAD_HI/WRITE)
//   DONE      out  1 in RUN
//   OVERFLOW  out  sticky: PM filled without a HALT word
//   WORDS     out  words written by the last/current load
//   STATE     out  current FSM state, for observation
//
// Handshake: a byte transfers on a rising edge where RX_VALID and RX_READY are
// both 1. RX_READY depends only on the state, never on RX_VALID, so the sender
// may hold RX_VALID/RX_DATA stable and wait; a byte presented while RX_READY=0
// is simply not taken.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                   ADDR_W   = 11,
  parameter int                   DATA_W   = 16,  // must be 2 x BYTE_W
  parameter int                   OPCODE_W = OPCODE_WIDTH,
  parameter logic [OPCODE_W-1:0]  HALT_OP  = HALT_OPCODE
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOAD_REQ,
  input  logic              RUN_REQ,
  input  logic [BYTE_W-1:0] RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              PM_WE,
  output logic [ADDR_W-1:0] PM_ADDR,
  output logic [DATA_W-1:0] PM_WDATA,
  output logic              CPU_RUN,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERFLOW,
  output logic [ADDR_W:0]   WORDS,
  output state_t            STATE
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr;       // address of the word being assembled
  logic [ADDR_W-1:0]   last_addr;  // address of the most recent write
  logic [ADDR_W:0]     words;
  logic [BYTE_W-1:0]   lo;
  logic [BYTE_W-1:0]   hi;
  logic                overflow;
  logic                accept;
  logic [OPCODE_W-1:0] opcode;
  logic                is_halt;

  assign accept  = RX_VALID & RX_READY;
  assign opcode  = PM_WDATA[DATA_W-1 -: OPCODE_W];
  assign is_halt = (opcode == HALT_OP);

  // Next state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    RX_READY  = 1'b0;
    PM_WE     = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    CPU_RUN   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (LOAD_REQ)     state_nxt = ST_LOAD_LO;
        else if (RUN_REQ) state_nxt = ST_RUN;
      end
      ST_LOAD_LO: begin
        RX_READY = 1'b1;
        BUSY     = 1'b1;
        if (LOAD_REQ)    state_nxt = ST_LOAD_LO;
        else if (accept) state_nxt = ST_LOAD_HI;
      end
      ST_LOAD_HI: begin
        RX_READY = 1'b1;
        BUSY     = 1'b1;
        // A restart drops the half-assembled word.
        if (LOAD_REQ)    state_nxt = ST_LOAD_LO;
        else if (accept) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        PM_WE = 1'b1;
        BUSY  = 1'b1;
        // The write in this cycle always completes, even on a restart.
        if (LOAD_REQ)                state_nxt = ST_LOAD_LO;
        else if (is_halt)            state_nxt = ST_RUN;
        else if (addr == ADDR_LAST)  state_nxt = ST_RUN;
        else                         state_nxt = ST_LOAD_LO;
      end
      ST_RUN: begin
        CPU_RUN = 1'b1;
        DONE    = 1'b1;
        if (LOAD_REQ) state_nxt = ST_LOAD_LO;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      addr      <= '0;
      last_addr <= '0;
      words     <= '0;
      lo        <= '0;
      hi        <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ST_LOAD_LO && accept) lo <= RX_DATA;
      if (state == ST_LOAD_HI && accept) hi <= RX_DATA;

      if (state == ST_WRITE) begin
        last_addr <= addr;
        words     <= words + (ADDR_W+1)'(1);
        if (!is_halt) begin
          // addr saturates at the top word; the FSM leaves for RUN instead.
          if (addr == ADDR_LAST) overflow <= 1'b1;
          else                   addr     <= addr + ADDR_W'(1);
        end
      end

      // Any LOAD_REQ starts a fresh load; it overrides the updates above.
      if (LOAD_REQ) begin
        addr     <= '0;
        words    <= '0;
        overflow <= 1'b0;
      end
    end
  end

  // PM_ADDR shows the live address only while writing, so it holds the last
  // written address otherwise (addr has already moved on by then).
  assign PM_ADDR  = PM_WE ? addr : last_addr;
  assign PM_WDATA = {hi, lo};
  assign OVERFLOW = overflow;
  assign WORDS    = words;
  assign STATE    = state;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: a full-size instance (ADDR_W=11) and a small
// instance (ADDR_W=3) for the fill-to-the-top case. A reference model turns
// a byte list into the expected list of PM writes, final WORDS and OVERFLOW.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int AW  = 11;
  localparam int AWS = 3;
  localparam int DW  = 16;
  localparam int W   = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       load_req, load_req_s, run_req, rx_valid;
  logic [7:0] rx_data;

  logic           rx_ready, pm_we, cpu_run, busy, done, overflow;
  logic [AW-1:0]  pm_addr;
  logic [DW-1:0]  pm_wdata;
  logic [AW:0]    words;
  state_t         state_dbg;

  logic           rx_ready_s, pm_we_s, cpu_run_s, busy_s, done_s, overflow_s;
  logic [AWS-1:0] pm_addr_s;
  logic [DW-1:0]  pm_wdata_s;
  logic [AWS:0]   words_s;
  state_t         state_dbg_s;

  program_loader #(.ADDR_W(AW)) dut (
    .CLK(clk), .RESET(reset), .LOAD_REQ(load_req), .RUN_REQ(run_req),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready),
    .PM_WE(pm_we), .PM_ADDR(pm_addr), .PM_WDATA(pm_wdata),
    .CPU_RUN(cpu_run), .BUSY(busy), .DONE(done), .OVERFLOW(overflow),
    .WORDS(words), .STATE(state_dbg)
  );

  program_loader #(.ADDR_W(AWS)) dut_s (
    .CLK(clk), .RESET(reset), .LOAD_REQ(load_req_s), .RUN_REQ(1'b0),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready_s),
    .PM_WE(pm_we_s), .PM_ADDR(pm_addr_s), .PM_WDATA(pm_wdata_s),
    .CPU_RUN(cpu_run_s), .BUSY(busy_s), .DONE(done_s), .OVERFLOW(overflow_s),
    .WORDS(words_s), .STATE(state_dbg_s)
  );

  // ---------------- write monitor ----------------
  logic [W-1:0] wr_q[$];
  logic [W-1:0] wr_q_s[$];
  int           ready_in_write = 0;

  always @(negedge clk) begin
    if (pm_we)   wr_q.push_back({pm_addr, pm_wdata});
    if (pm_we_s) wr_q_s.push_back({{(AW-AWS){1'b0}}, pm_addr_s, pm_wdata_s});
    if ((pm_we && rx_ready) || (pm_we_s && rx_ready_s))
      ready_in_write <= ready_in_write + 1;
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  int rd    = 0;
  int rd_s  = 0;
  logic [7:0] stim_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input bit sel);
    if (sel) load_req_s = 1'b1;
    else     load_req   = 1'b1;
    tick();
    load_req   = 1'b0;
    load_req_s = 1'b0;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input int max_gap);
    int gap;
    bit hs;
    bit got;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    got      = 1'b0;
    for (int k = 0; k < 100; k++) begin
      hs = sel ? rx_ready_s : rx_ready;
      tick();
      if (hs) begin
        got = 1'b1;
        break;
      end
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom());
    check("byte_handshake", 32'(got), 32'd1);
  endtask

  task automatic check_idle(input string tag, input bit sel);
    if (!sel) begin
      check({tag, "_rx_ready"}, 32'(rx_ready), 0);
      check({tag, "_pm_we"},    32'(pm_we), 0);
      check({tag, "_pm_addr"},  32'(pm_addr), 0);
      check({tag, "_pm_wdata"}, 32'(pm_wdata), 0);
      check({tag, "_cpu_run"},  32'(cpu_run), 0);
      check({tag, "_busy"},     32'(busy), 0);
      check({tag, "_done"},     32'(done), 0);
      check({tag, "_overflow"}, 32'(overflow), 0);
      check({tag, "_words"},    32'(words), 0);
      check({tag, "_state"},    32'(state_dbg), 32'(ST_IDLE));
    end else begin
      check({tag, "_rx_ready"}, 32'(rx_ready_s), 0);
      check({tag, "_pm_we"},    32'(pm_we_s), 0);
      check({tag, "_pm_wdata"}, 32'(pm_wdata_s), 0);
      check({tag, "_cpu_run"},  32'(cpu_run_s), 0);
      check({tag, "_words"},    32'(words_s), 0);
      check({tag, "_state"},    32'(state_dbg_s), 32'(ST_IDLE));
    end
  endtask

  // Reference model plus driver: from the byte list, work out which words get
  // written where, then feed exactly those bytes and compare what happened.
  // Expects the loader to already be in LOAD_LO.
  task automatic run_load(input bit sel, input logic [7:0] bytes[$],
                          input int max_gap, input string tag);
    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] word;
    int            depth;
    int            nwords;
    bit            ovf;
    int            got_n;
    logic [W-1:0]  got_w;

    depth  = sel ? (1 << AWS) : (1 << AW);
    nwords = 0;
    ovf    = 1'b0;
    for (int w = 0; 2*w + 1 < bytes.size(); w++) begin
      word = {bytes[2*w+1], bytes[2*w]};
      exp_q.push_back({AW'(w), word});
      nwords++;
      if (word[DW-1 -: OPCODE_WIDTH] == HALT_OPCODE) break;
      if (w == depth - 1) begin
        ovf = 1'b1;
        break;
      end
    end

    for (int i = 0; i < 2*nwords; i++) send_byte(sel, bytes[i], max_gap);

    // One cycle after the last byte: the final write, CPU still held.
    check({tag, "_last_we"},      32'(sel ? pm_we_s : pm_we), 1);
    check({tag, "_last_cpu_off"}, 32'(sel ? cpu_run_s : cpu_run), 0);
    tick();
    check({tag, "_cpu_run"},  32'(sel ? cpu_run_s : cpu_run), 1);
    check({tag, "_done"},     32'(sel ? done_s : done), 1);
    check({tag, "_busy"},     32'(sel ? busy_s : busy), 0);
    check({tag, "_words"},    32'(sel ? 32'(words_s) : 32'(words)), 32'(nwords));
    check({tag, "_overflow"}, 32'(sel ? overflow_s : overflow), 32'(ovf));
    check({tag, "_addr_hold"}, 32'(sel ? 32'(pm_addr_s) : 32'(pm_addr)), 32'(nwords - 1));
    repeat (3) tick();

    got_n = sel ? (wr_q_s.size() - rd_s) : (wr_q.size() - rd);
    check({tag, "_write_count"}, 32'(got_n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
      got_w = sel ? wr_q_s[rd_s + i] : wr_q[rd + i];
      check($sformatf("%s_write%0d_addr", tag, i), 32'(got_w[W-1:DW]), 32'(exp_q[i][W-1:DW]));
      check($sformatf("%s_write%0d_data", tag, i), 32'(got_w[DW-1:0]), 32'(exp_q[i][DW-1:0]));
    end
    if (sel) rd_s = wr_q_s.size();
    else     rd   = wr_q.size();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int         n_before;
    logic [15:0] wd;
    int         n;

    reset = 1'b0; load_req = 1'b0; load_req_s = 1'b0; run_req = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) tick();
    check_idle("reset", 1'b0);
    check_idle("reset_small", 1'b1);
    reset = 1'b1;
    tick();

    // Basic load. 0x0800 carries opcode 1 (bits 15:11), so it is an ordinary
    // word; the trailing 0x0000 is the HALT.
    pulse_load(1'b0);
    check("t1_busy", 32'(busy), 1);
    check("t1_rx_ready", 32'(rx_ready), 1);
    check("t1_cpu_held", 32'(cpu_run), 0);
    stim_q = '{8'h34, 8'h12, 8'h00, 8'h08, 8'h00, 8'h00};
    run_load(1'b0, stim_q, 0, "t1");
    check("t1_pm0", 32'(wr_q[0][DW-1:0]), 32'h1234);

    // Reload from RUN with random gaps between bytes.
    pulse_load(1'b0);
    check("t2_cpu_off", 32'(cpu_run), 0);
    check("t2_words_clr", 32'(words), 0);
    run_req = 1'b1;                         // ignored while busy
    tick();
    run_req = 1'b0;
    check("t2_runreq_ignored", 32'(state_dbg), 32'(ST_LOAD_LO));
    run_load(1'b0, stim_q, 4, "t2");

    // Fill the small memory without a HALT.
    pulse_load(1'b1);
    stim_q.delete();
    for (int i = 1; i <= 8; i++) begin
      stim_q.push_back(8'(i));
      stim_q.push_back(8'h08);
    end
    stim_q.push_back(8'h00);
    stim_q.push_back(8'h00);
    run_load(1'b1, stim_q, 2, "t3");
    n_before = wr_q_s.size();
    rx_valid = 1'b1;
    repeat (3) tick();
    check("t3_backpressure", 32'(rx_ready_s), 0);
    rx_valid = 1'b0;
    tick();
    check("t3_no_extra_write", 32'(wr_q_s.size()), 32'(n_before));

    // Restart partway into the second word.
    pulse_load(1'b0);
    send_byte(1'b0, 8'h34, 0);
    send_byte(1'b0, 8'h12, 0);
    send_byte(1'b0, 8'hAB, 0);
    check("t4_in_load_hi", 32'(state_dbg), 32'(ST_LOAD_HI));
    pulse_load(1'b0);
    check("t4_words_restart", 32'(words), 0);
    check("t4_state_restart", 32'(state_dbg), 32'(ST_LOAD_LO));
    check("t4_pre_write_count", 32'(wr_q.size() - rd), 1);
    check("t4_pre_write", 32'(wr_q[rd]), 32'({AW'(0), 16'h1234}));
    rd = wr_q.size();
    stim_q = '{8'h99, 8'h77, 8'h55, 8'h66, 8'h21, 8'h03};
    run_load(1'b0, stim_q, 1, "t4");

    // RUN_REQ from IDLE, then LOAD_REQ and RUN_REQ together.
    reset = 1'b0; tick(); reset = 1'b1; tick();
    n_before = wr_q.size();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    check("t5_cpu_run", 32'(cpu_run), 1);
    check("t5_done", 32'(done), 1);
    repeat (2) tick();
    check("t5_no_write", 32'(wr_q.size()), 32'(n_before));
    reset = 1'b0; tick(); reset = 1'b1; tick();
    load_req = 1'b1; run_req = 1'b1;
    tick();
    load_req = 1'b0; run_req = 1'b0;
    check("t5_load_wins", 32'(state_dbg), 32'(ST_LOAD_LO));
    check("t5_cpu_held", 32'(cpu_run), 0);
    stim_q = '{8'hEF, 8'hBE, 8'h00, 8'h01};
    run_load(1'b0, stim_q, 2, "t5");

    // Reset in LOAD_HI, then a normal load.
    pulse_load(1'b0);
    send_byte(1'b0, 8'h5A, 0);
    reset = 1'b0;
    tick();
    check_idle("t6_reset", 1'b0);
    reset = 1'b1;
    tick();
    pulse_load(1'b0);
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h07, 8'h00};
    run_load(1'b0, stim_q, 2, "t6");

    // Random programs: non-HALT words followed by one HALT word.
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(12, 1));
      stim_q.delete();
      for (int i = 0; i < n; i++) begin
        wd[15:11] = (i == n-1) ? HALT_OPCODE : 5'($urandom_range(31, 1));
        wd[10:0]  = 11'($urandom());
        stim_q.push_back(wd[7:0]);
        stim_q.push_back(wd[15:8]);
      end
      if (r % 2 == 0) begin
        pulse_load(1'b0);
        run_load(1'b0, stim_q, 3, "rand_big");
      end else begin
        pulse_load(1'b1);
        run_load(1'b1, stim_q, 3, "rand_small");
      end
    end

    check("ready_low_in_write", 32'(ready_in_write), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
